// File: rtl/ui_event_pkg.sv
// Shared constants for the KEY/SW event device: register map and CTRL bit layout.
package ui_event_pkg;

    localparam logic [31:0] UI_KDATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] UI_KCTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] UI_SDATA_ADDR = 32'hF000_0014;
    localparam logic [31:0] UI_SCTRL_ADDR = 32'hF000_0114;

    localparam int unsigned CTRL_READY   = 0;
    localparam int unsigned CTRL_OVERRUN = 2;
    localparam int unsigned CTRL_IE      = 8;
    localparam int unsigned CTRL_W       = 16;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned SW_W  = 10;

    // Pack status bits into the low half-word of a CTRL register.
    function automatic logic [CTRL_W-1:0] ctrl_word(input logic ready,
                                                    input logic overrun,
                                                    input logic ie);
        logic [CTRL_W-1:0] w;
        w               = '0;
        w[CTRL_READY]   = ready;
        w[CTRL_OVERRUN] = overrun;
        w[CTRL_IE]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/ui_event_channel.sv
// One event channel: captures changes of a debounced vector and keeps
// sticky ready/overrun status plus the interrupt enable.
module ui_event_channel
    import ui_event_pkg::*;
#(
    parameter int unsigned W = KEY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] deb,
    input  logic         consume,
    input  logic         ctrl_wr,
    input  logic         wr_ovr,
    input  logic         wr_ie,
    output logic [W-1:0] data,
    output logic         ready,
    output logic         overrun,
    output logic         ie
);

    logic [W-1:0] data_q, data_d;
    logic         ready_q, ready_d;
    logic         overrun_q, overrun_d;
    logic         ie_q, ie_d;
    logic         chg;

    always_comb begin
        data_d    = data_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        ie_d      = ie_q;
        chg       = (deb != data_q);

        if (consume) begin
            ready_d = 1'b0;
        end
        if (ctrl_wr) begin
            ie_d = wr_ie;
            if (!wr_ovr) begin
                overrun_d = 1'b0;
            end
        end
        // A capture beats both the consume and an overrun-clearing write.
        if (chg) begin
            data_d  = deb;
            ready_d = 1'b1;
            if (ready_q && !consume) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= deb;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            ie_q      <= 1'b0;
        end else begin
            data_q    <= data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            ie_q      <= ie_d;
        end
    end

    assign data    = data_q;
    assign ready   = ready_q;
    assign overrun = overrun_q;
    assign ie      = ie_q;

endmodule

// File: rtl/ui_event_device.sv
// Memory-mapped KEY/SW event device: address decode, read mux and interrupt.
module ui_event_device
    import ui_event_pkg::*;
#(
    parameter int unsigned           DBITS      = 32,
    parameter int unsigned           ABITS      = 32,
    parameter logic [ABITS-1:0]      KDATA_ADDR = ABITS'(UI_KDATA_ADDR),
    parameter logic [ABITS-1:0]      KCTRL_ADDR = ABITS'(UI_KCTRL_ADDR),
    parameter logic [ABITS-1:0]      SDATA_ADDR = ABITS'(UI_SDATA_ADDR),
    parameter logic [ABITS-1:0]      SCTRL_ADDR = ABITS'(UI_SCTRL_ADDR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ABITS-1:0]   addr,
    input  logic               rdEn,
    input  logic               wrtEn,
    input  logic [DBITS-1:0]   dataIn,
    input  logic [KEY_W-1:0]   keyDeb,
    input  logic [SW_W-1:0]    swDeb,
    output logic [DBITS-1:0]   dataOut,
    output logic               hit,
    output logic               intr
);

    logic sel_kdata, sel_kctrl, sel_sdata, sel_sctrl;
    logic k_consume, s_consume, k_ctrl_wr, s_ctrl_wr;

    logic [KEY_W-1:0] k_data;
    logic [SW_W-1:0]  s_data;
    logic             k_ready, k_overrun, k_ie;
    logic             s_ready, s_overrun, s_ie;
    logic             unused_din_c;

    assign sel_kdata = (addr == KDATA_ADDR);
    assign sel_kctrl = (addr == KCTRL_ADDR);
    assign sel_sdata = (addr == SDATA_ADDR);
    assign sel_sctrl = (addr == SCTRL_ADDR);
    assign hit       = sel_kdata | sel_kctrl | sel_sdata | sel_sctrl;

    // A cycle with both strobes is a store; it never consumes.
    assign k_consume = rdEn & ~wrtEn & sel_kdata;
    assign s_consume = rdEn & ~wrtEn & sel_sdata;
    assign k_ctrl_wr = wrtEn & sel_kctrl;
    assign s_ctrl_wr = wrtEn & sel_sctrl;

    assign unused_din_c = ^{dataIn[DBITS-1:CTRL_IE+1], dataIn[CTRL_IE-1:CTRL_OVERRUN+1],
                            dataIn[CTRL_OVERRUN-1:0]};

    ui_event_channel #(.W(KEY_W)) u_key (
        .clk     (clk),
        .reset   (reset),
        .deb     (keyDeb),
        .consume (k_consume),
        .ctrl_wr (k_ctrl_wr),
        .wr_ovr  (dataIn[CTRL_OVERRUN]),
        .wr_ie   (dataIn[CTRL_IE]),
        .data    (k_data),
        .ready   (k_ready),
        .overrun (k_overrun),
        .ie      (k_ie)
    );

    ui_event_channel #(.W(SW_W)) u_sw (
        .clk     (clk),
        .reset   (reset),
        .deb     (swDeb),
        .consume (s_consume),
        .ctrl_wr (s_ctrl_wr),
        .wr_ovr  (dataIn[CTRL_OVERRUN]),
        .wr_ie   (dataIn[CTRL_IE]),
        .data    (s_data),
        .ready   (s_ready),
        .overrun (s_overrun),
        .ie      (s_ie)
    );

    always_comb begin
        dataOut = '0;
        if (sel_kdata) begin
            dataOut = DBITS'(k_data);
        end else if (sel_kctrl) begin
            dataOut = DBITS'(ctrl_word(k_ready, k_overrun, k_ie));
        end else if (sel_sdata) begin
            dataOut = DBITS'(s_data);
        end else if (sel_sctrl) begin
            dataOut = DBITS'(ctrl_word(s_ready, s_overrun, s_ie));
        end
    end

    assign intr = (k_ready & k_ie) | (s_ready & s_ie);

endmodule

// File: tb/tb_ui_event_device.sv
// Directed vector bench for ui_event_device: each record drives one cycle and
// checks the combinational outputs seen before that cycle's rising edge.
module tb_ui_event_device;

    localparam logic [31:0] KDATA = 32'hF000_0010;
    localparam logic [31:0] KCTRL = 32'hF000_0110;
    localparam logic [31:0] SDATA = 32'hF000_0014;
    localparam logic [31:0] SCTRL = 32'hF000_0114;
    localparam logic [31:0] NOREG = 32'hF000_0018;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  key;
        logic [9:0]  sw;
        logic [31:0] dout;
        logic        hit;
        logic        intr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rdEn, wrtEn;
    logic [31:0] dataIn;
    logic [3:0]  keyDeb;
    logic [9:0]  swDeb;
    logic [31:0] dataOut;
    logic        hit, intr;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];
    vec_t post_rst[$];

    always #5 clk = ~clk;

    ui_event_device dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .rdEn    (rdEn),
        .wrtEn   (wrtEn),
        .dataIn  (dataIn),
        .keyDeb  (keyDeb),
        .swDeb   (swDeb),
        .dataOut (dataOut),
        .hit     (hit),
        .intr    (intr)
    );

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                                logic [3:0] k, logic [9:0] s,
                                logic [31:0] eo, logic eh, logic ei);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.din = d; v.key = k; v.sw = s;
        v.dout = eo; v.hit = eh; v.intr = ei;
        return v;
    endfunction

    // Drive one record at the falling edge, check just after, let the rising edge capture.
    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        rdEn = v.rd; wrtEn = v.wr; addr = v.addr; dataIn = v.din;
        keyDeb = v.key; swDeb = v.sw;
        #1;
        n_vec++;
        if (dataOut !== v.dout) begin
            n_err++;
            $display("FAIL %s[%0d] dataOut: got %h expected %h", tag, idx, dataOut, v.dout);
        end
        if (hit !== v.hit) begin
            n_err++;
            $display("FAIL %s[%0d] hit: got %b expected %b", tag, idx, hit, v.hit);
        end
        if (intr !== v.intr) begin
            n_err++;
            $display("FAIL %s[%0d] intr: got %b expected %b", tag, idx, intr, v.intr);
        end
    endtask

    initial begin
        //          rd wr addr   din        key      sw       dout       hit  intr
        // reset with keys = 2, no spurious event afterwards
        vecs.push_back(mk(0, 0, KDATA, 0,       4'h2, 10'h000, 32'h002, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h2, 10'h000, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h2, 10'h000, 32'h000, 1, 0));
        // switch capture and consuming read
        vecs.push_back(mk(0, 0, SCTRL, 0,       4'h2, 10'h005, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, SCTRL, 0,       4'h2, 10'h005, 32'h001, 1, 0));
        vecs.push_back(mk(1, 0, SDATA, 0,       4'h2, 10'h005, 32'h005, 1, 0));
        vecs.push_back(mk(0, 0, SCTRL, 0,       4'h2, 10'h005, 32'h000, 1, 0));
        // two key changes without a read -> overrun
        vecs.push_back(mk(0, 0, KDATA, 0,       4'h1, 10'h005, 32'h002, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h3, 10'h005, 32'h001, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h3, 10'h005, 32'h005, 1, 0));
        vecs.push_back(mk(0, 0, KDATA, 0,       4'h3, 10'h005, 32'h003, 1, 0));
        vecs.push_back(mk(0, 1, KCTRL, 32'h000, 4'h3, 10'h005, 32'h005, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h3, 10'h005, 32'h001, 1, 0));
        // re-create overrun, then writing 1 to it must leave it set
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h2, 10'h005, 32'h001, 1, 0));
        vecs.push_back(mk(0, 1, KCTRL, 32'h004, 4'h2, 10'h005, 32'h005, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h2, 10'h005, 32'h005, 1, 0));
        vecs.push_back(mk(0, 1, KCTRL, 32'h000, 4'h2, 10'h005, 32'h005, 1, 0));
        vecs.push_back(mk(1, 0, KDATA, 0,       4'h2, 10'h005, 32'h002, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h2, 10'h005, 32'h000, 1, 0));
        // interrupt enable, key0 press, consume drops intr
        vecs.push_back(mk(0, 1, KCTRL, 32'h100, 4'h2, 10'h005, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h3, 10'h005, 32'h100, 1, 0));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h3, 10'h005, 32'h101, 1, 1));
        vecs.push_back(mk(1, 0, KDATA, 0,       4'h3, 10'h005, 32'h003, 1, 1));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h3, 10'h005, 32'h100, 1, 0));
        // change coinciding with a consuming read while ready
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h1, 10'h005, 32'h100, 1, 0));
        vecs.push_back(mk(1, 0, KDATA, 0,       4'h0, 10'h005, 32'h001, 1, 1));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h0, 10'h005, 32'h101, 1, 1));
        vecs.push_back(mk(0, 0, KDATA, 0,       4'h0, 10'h005, 32'h000, 1, 1));
        // unmapped address, ignored data write
        vecs.push_back(mk(1, 0, NOREG, 0,       4'h0, 10'h005, 32'h000, 0, 1));
        vecs.push_back(mk(0, 1, SDATA, 32'h3FF, 4'h0, 10'h005, 32'h005, 1, 1));
        vecs.push_back(mk(0, 0, SDATA, 0,       4'h0, 10'h005, 32'h005, 1, 1));
        // overrun-clearing write loses to a same-cycle overrun
        vecs.push_back(mk(0, 1, KCTRL, 32'h100, 4'h4, 10'h005, 32'h101, 1, 1));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h4, 10'h005, 32'h105, 1, 1));
        // read+write together is a write only: no consume
        vecs.push_back(mk(1, 1, KDATA, 32'h000, 4'h4, 10'h005, 32'h004, 1, 1));
        vecs.push_back(mk(0, 0, KCTRL, 0,       4'h4, 10'h005, 32'h105, 1, 1));
        // switch interrupt path
        vecs.push_back(mk(0, 1, SCTRL, 32'h100, 4'h4, 10'h005, 32'h000, 1, 1));
        vecs.push_back(mk(0, 1, KCTRL, 32'h000, 4'h4, 10'h005, 32'h105, 1, 1));
        vecs.push_back(mk(0, 0, SCTRL, 0,       4'h4, 10'h006, 32'h100, 1, 0));
        vecs.push_back(mk(0, 0, SCTRL, 0,       4'h4, 10'h006, 32'h101, 1, 1));

        // after a mid-operation reset (keys 5, switches 7)
        post_rst.push_back(mk(0, 0, SCTRL, 0,   4'h5, 10'h007, 32'h000, 1, 0));
        post_rst.push_back(mk(0, 0, KCTRL, 0,   4'h5, 10'h007, 32'h000, 1, 0));
        post_rst.push_back(mk(0, 0, SDATA, 0,   4'h5, 10'h007, 32'h007, 1, 0));
        post_rst.push_back(mk(0, 0, KDATA, 0,   4'h5, 10'h007, 32'h005, 1, 0));
        post_rst.push_back(mk(0, 0, KCTRL, 0,   4'h5, 10'h007, 32'h000, 1, 0));

        reset = 1'b1; rdEn = 1'b0; wrtEn = 1'b0; addr = '0; dataIn = '0;
        keyDeb = 4'h2; swDeb = 10'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], "vec", i);
        end

        // reset during a cycle that also carries a change, a consume and a write
        @(negedge clk);
        reset = 1'b1; rdEn = 1'b1; wrtEn = 1'b0; addr = SDATA;
        keyDeb = 4'h5; swDeb = 10'h007;
        @(negedge clk);
        reset = 1'b0; rdEn = 1'b0; wrtEn = 1'b1; addr = SCTRL; dataIn = 32'h100;
        @(negedge clk);
        reset = 1'b1; wrtEn = 1'b1;
        @(negedge clk);
        reset = 1'b0; wrtEn = 1'b0;
        for (int i = 0; i < post_rst.size(); i++) begin
            apply(post_rst[i], "rst", i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
